// File: rtl/mpdmac_sched.sv
// rtl/mpdmac_sched.sv - round-robin job scheduler feeding one shared mirror-padding DMA engine
// Optional per-channel interrupt block is built only when MPDMAC_SCHED_IRQ_EN is defined.
module mpdmac_sched #(
    parameter int NCH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    req_valid_i,
    output logic [NCH-1:0]    req_ready_o,
    input  logic [NCH*32-1:0] req_src_addr_i,
    input  logic [NCH*32-1:0] req_dst_addr_i,
    input  logic [NCH*6-1:0]  req_mat_width_i,
    output logic [NCH-1:0]    cmpl_o,
    output logic              err_o,
    output logic              busy_o,
    output logic [31:0]       eng_src_addr_o,
    output logic [31:0]       eng_dst_addr_o,
    output logic [5:0]        eng_mat_width_o,
    output logic              eng_start_o,
    input  logic              eng_done_i
`ifdef MPDMAC_SCHED_IRQ_EN
    ,
    output logic              irq_o,
    output logic [NCH-1:0]    irq_status_o,
    input  logic [NCH-1:0]    irq_clr_i
`endif
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_CMPL  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] rr_q, rr_d;
    logic [CW-1:0] ch_q, ch_d;
    logic          err_q, err_d;
    logic [31:0]   src_q, src_d;
    logic [31:0]   dst_q, dst_d;
    logic [5:0]    w_q, w_d;

    logic          gnt_found;
    logic [CW-1:0] gnt_idx;
    logic [CW-1:0] scan_idx;
    logic          grant;
    logic          width_ok;
    logic [31:0]   sel_src;
    logic [31:0]   sel_dst;
    logic [5:0]    sel_w;

    // First pending channel at or after the round-robin pointer, wrapping modulo NCH.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < NCH; i++) begin
            scan_idx = CW'((int'(rr_q) + i) % NCH);
            if (!gnt_found && req_valid_i[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        sel_src = '0;
        sel_dst = '0;
        sel_w   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt_idx == CW'(k)) begin
                sel_src = req_src_addr_i[32*k +: 32];
                sel_dst = req_dst_addr_i[32*k +: 32];
                sel_w   = req_mat_width_i[6*k +: 6];
            end
        end
    end

    // rst_n gates the accept pulse so no ready escapes while the block is held in reset.
    assign grant    = rst_n && (state_q == S_IDLE) && gnt_found && eng_done_i;
    assign width_ok = !w_q[0] && (w_q >= 6'd2) && (w_q <= 6'd60);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        ch_d    = ch_q;
        err_d   = err_q;
        src_d   = src_q;
        dst_d   = dst_q;
        w_d     = w_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    ch_d    = gnt_idx;
                    rr_d    = CW'((int'(gnt_idx) + 1) % NCH);
                    src_d   = sel_src;
                    dst_d   = sel_dst;
                    w_d     = sel_w;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (width_ok) begin
                    state_d = S_START;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_CMPL;
                end
            end
            S_START: begin
                if (!eng_done_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (eng_done_i) begin
                    state_d = S_CMPL;
                end
            end
            S_CMPL: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            ch_q    <= '0;
            err_q   <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            ch_q    <= ch_d;
            err_q   <= err_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            w_q     <= w_d;
        end
    end

    assign req_ready_o     = grant ? (NCH'(1) << gnt_idx) : '0;
    assign cmpl_o          = (state_q == S_CMPL) ? (NCH'(1) << ch_q) : '0;
    assign err_o           = (state_q == S_CMPL) && err_q;
    assign busy_o          = (state_q != S_IDLE);
    // Start stays up until the engine reports busy; it ignores the extra cycle.
    assign eng_start_o     = (state_q == S_START);
    assign eng_src_addr_o  = src_q;
    assign eng_dst_addr_o  = dst_q;
    assign eng_mat_width_o = w_q;

`ifdef MPDMAC_SCHED_IRQ_EN
    logic [NCH-1:0] irq_status_q, irq_status_d;
    logic           irq_q;

    // A completion in the same cycle as a clear keeps the status bit set.
    assign irq_status_d = (irq_status_q & ~irq_clr_i) | cmpl_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_status_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            irq_status_q <= irq_status_d;
            irq_q        <= |irq_status_d;
        end
    end

    assign irq_status_o = irq_status_q;
    assign irq_o        = irq_q;
`endif

endmodule
